// File: rtl/integ_pkg.sv
//------------------------------------------------------------------------------
// Module  : integ_pkg
// Purpose : Shared defaults, FSM state type and FIFO entry layout for the
//           integrator result capture stage.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package integ_pkg;

    localparam int c_data_w     = 13;
    localparam int c_depth      = 4;
    localparam int c_win_cycles = 4;
    localparam int c_avg_shift  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } integ_state_t;

    // One captured window: short flag above the sum.
    typedef struct packed {
        logic                short_win;
        logic [c_data_w-1:0] sum;
    } integ_entry_t;

    localparam int c_entry_w = $bits(integ_entry_t);

endpackage

`default_nettype wire

// File: rtl/integ_sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : integ_sync_fifo
// Purpose : Synchronous FIFO, DEPTH x WIDTH, head read combinationally.
//           A push while full is accepted only when a pop happens on the
//           same edge.
// Ports   : clock, acc_rst2 (async, active-high)
//           push/push_data   - write request and data
//           pop              - read request (ignored when empty)
//           head_data        - entry at the read pointer
//           count/full/empty - occupancy status
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module integ_sync_fifo #(
    parameter int DEPTH = 4,              // power of two, >= 2
    parameter int WIDTH = 14
) (
    input  logic                     clock,
    input  logic                     acc_rst2,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_aw = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign head_data = r_mem[r_rd_ptr[c_aw-1:0]];

    assign w_do_pop  = pop && !empty;
    // When full, the slot being written is the head being popped this edge;
    // the head was already consumed combinationally, so reuse is safe.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clock or posedge acc_rst2) begin
        if (acc_rst2) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; readers gate the head with empty.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/integ_result_fifo.sv
//------------------------------------------------------------------------------
// Module  : integ_result_fifo
// Purpose : Captures the integrator's final sum at the end of every acc_en
//           window, queues it, and offers {sum, average, short flag} to a
//           valid/ready consumer. Counts windows dropped on a full queue.
// Ports   : clock, acc_rst2 (async, active-high)
//           acc_en, y_in                  - integrator enable and running sum
//           out_valid/out_ready           - consumer handshake
//           out_sum/out_avg/out_short     - head entry, zero when empty
//           count/full                    - queue occupancy
//           ovf_cnt                       - dropped windows, saturating
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module integ_result_fifo
    import integ_pkg::*;
#(
    parameter int DATA_W     = c_data_w,      // must match the entry layout
    parameter int DEPTH      = c_depth,
    parameter int WIN_CYCLES = c_win_cycles,
    parameter int AVG_SHIFT  = c_avg_shift
) (
    input  logic                    clock,
    input  logic                    acc_rst2,
    input  logic                    acc_en,
    input  logic [DATA_W-1:0]       y_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_sum,
    output logic [DATA_W-1:0]       out_avg,
    output logic                    out_short,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic [3:0]              ovf_cnt
);

    localparam logic [2:0] c_win_nom = 3'(WIN_CYCLES);
    localparam logic [2:0] c_win_max = 3'd7;

    integ_state_t   r_state;
    integ_state_t   w_state_nxt;
    logic [2:0]     r_win_cnt;
    logic [2:0]     w_win_nxt;
    logic           w_capture;
    logic [3:0]     r_ovf_cnt;

    integ_entry_t   w_push_entry;
    integ_entry_t   w_head_entry;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;

    // Window FSM: a capture happens on the first edge where acc_en drops.
    always_ff @(posedge clock or posedge acc_rst2) begin
        if (acc_rst2) begin
            r_state   <= IDLE;
            r_win_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_win_cnt <= w_win_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_cnt;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (acc_en) begin
                    w_state_nxt = ACCUM;
                    w_win_nxt   = 3'd1;
                end
            end
            ACCUM: begin
                if (acc_en) begin
                    if (r_win_cnt != c_win_max) w_win_nxt = r_win_cnt + 3'd1;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                    w_win_nxt   = 3'd0;
                end
            end
        endcase
    end

    assign w_push_entry.short_win = (r_win_cnt != c_win_nom);
    assign w_push_entry.sum       = y_in;
    assign w_pop                  = out_ready && !w_empty;

    integ_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clock     (clock),
        .acc_rst2  (acc_rst2),
        .push      (w_capture),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head_entry),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // A capture is lost only when full and the consumer is not freeing a slot.
    always_ff @(posedge clock or posedge acc_rst2) begin
        if (acc_rst2) begin
            r_ovf_cnt <= 4'd0;
        end else if (w_capture && w_full && !w_pop && (r_ovf_cnt != 4'hF)) begin
            r_ovf_cnt <= r_ovf_cnt + 4'd1;
        end
    end

    assign out_valid = !w_empty;
    assign out_sum   = w_empty ? '0   : w_head_entry.sum;
    assign out_short = w_empty ? 1'b0 : w_head_entry.short_win;
    assign out_avg   = out_sum >> AVG_SHIFT;
    assign full      = w_full;
    assign ovf_cnt   = r_ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_integ_result_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_integ_result_fifo
// Purpose : Self-checking bench for integ_result_fifo. A reference model
//           tracks acc_en run lengths and a queue of expected results; a
//           monitor compares the DUT outputs against the queue every cycle.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_integ_result_fifo;

    localparam int c_dw    = 13;
    localparam int c_depth = 4;
    localparam int c_win   = 4;

    logic             clock    = 1'b0;
    logic             acc_rst2 = 1'b1;
    logic             acc_en   = 1'b0;
    logic [c_dw-1:0]  y_in     = '0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [c_dw-1:0]  out_sum;
    logic [c_dw-1:0]  out_avg;
    logic             out_short;
    logic [2:0]       count;
    logic             full;
    logic [3:0]       ovf_cnt;

    integ_result_fifo dut (
        .clock     (clock),
        .acc_rst2  (acc_rst2),
        .acc_en    (acc_en),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_avg   (out_avg),
        .out_short (out_short),
        .count     (count),
        .full      (full),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        bit short_w;
        int sum;
    } exp_t;

    exp_t exp_q[$];
    bit   m_in_win = 1'b0;
    int   m_len    = 0;
    int   m_ovf    = 0;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   max_cnt  = 0;

    // A window is a run of acc_en=1; it ends on the first low sample, whose
    // y_in is the result. Length counts high samples, capped at 7.
    always @(posedge clock or posedge acc_rst2) begin
        if (acc_rst2) begin
            exp_q.delete();
            m_in_win = 1'b0;
            m_len    = 0;
            m_ovf    = 0;
        end else begin
            int  sz;
            bit  popped;
            exp_t e;
            sz     = exp_q.size();
            popped = (sz > 0) && out_ready;
            if (popped) void'(exp_q.pop_front());
            if (m_in_win && !acc_en) begin
                e.short_w = (m_len != c_win);
                e.sum     = int'(y_in);
                if (sz < c_depth || popped) exp_q.push_back(e);
                else if (m_ovf < 15) m_ovf++;
                m_in_win = 1'b0;
                m_len    = 0;
            end else if (acc_en) begin
                m_in_win = 1'b1;
                m_len    = (m_len < 7) ? m_len + 1 : 7;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        int sz;
        sz = exp_q.size();
        if (sz > max_cnt) max_cnt = sz;
        chk("out_valid", int'(out_valid), (sz > 0) ? 1 : 0);
        chk("count",     int'(count), sz);
        chk("full",      int'(full), (sz == c_depth) ? 1 : 0);
        chk("ovf_cnt",   int'(ovf_cnt), m_ovf);
        if (sz > 0) begin
            chk("out_sum",   int'(out_sum), exp_q[0].sum);
            chk("out_avg",   int'(out_avg), exp_q[0].sum / 4);
            chk("out_short", int'(out_short), int'(exp_q[0].short_w));
        end else begin
            chk("out_sum_empty",   int'(out_sum), 0);
            chk("out_avg_empty",   int'(out_avg), 0);
            chk("out_short_empty", int'(out_short), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit en, input int y, input bit rdy);
        @(negedge clock);
        #1;
        acc_en    = en;
        y_in      = c_dw'(y);
        out_ready = rdy;
    endtask

    // n accumulate cycles ramping to fin, then the capture cycle at fin.
    task automatic window(input int n, input int fin, input bit rdy, input bit rdy_cap);
        for (int i = 1; i <= n; i++) cyc(1'b1, (fin * i) / n, rdy);
        cyc(1'b0, fin, rdy_cap);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 acc_rst2 = 1'b1;
        acc_en    = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        #2 acc_rst2 = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #2 acc_rst2 = 1'b0;

        // Nominal 4-cycle window.
        window(4, 1000, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        drain(2);

        // Short window after reset.
        do_reset();
        window(2, 50, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        drain(2);

        // Overflow: five windows into a 4-deep queue, then drain.
        for (int k = 1; k <= 5; k++) window(4, k * 100, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        drain(5);

        // Full queue, capture coinciding with a pop.
        for (int k = 1; k <= 4; k++) window(4, k * 10, 1'b0, 1'b0);
        window(4, 777, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0);
        drain(5);

        // Reset during the third accumulate cycle with two entries queued.
        window(4, 111, 1'b0, 1'b0);
        window(3, 222, 1'b0, 1'b0);
        cyc(1'b1, 20, 1'b0);
        cyc(1'b1, 40, 1'b0);
        @(negedge clock);
        #1 acc_en = 1'b1;
        y_in = 13'd60;
        #1 acc_rst2 = 1'b1;
        #1 acc_rst2 = 1'b0;
        acc_en = 1'b0;
        cyc(1'b0, 0, 1'b0);
        window(4, 1500, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        drain(2);

        // Wrap-around with a consumer that is always ready.
        max_cnt = 0;
        for (int k = 1; k <= 10; k++) window(4, k * 100, 1'b1, 1'b1);
        drain(2);
        chk("wrap_max_count", max_cnt, 1);

        // Randomised traffic, including long windows and one mid-run reset.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                int'($urandom_range(0, 1500)),
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
            if (i == 300) do_reset();
        end
        drain(6);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
